// File: rtl/nn_mul_pkg.sv
// nn_mul_pkg: default widths, requester id type and round-robin pick helper
// shared by the multiplier-sharing arbiter.
package nn_mul_pkg;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DIN0_WIDTH = 5;
    localparam int DEF_DIN1_WIDTH = 6;
    localparam int DEF_DOUT_WIDTH = 10;
    localparam int DEF_ID_WIDTH   = 2;
    localparam int MAX_REQ        = 16;

    typedef logic [DEF_ID_WIDTH-1:0] mul_id_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // First asserted valid after ptr, wrapping modulo n; the lowest offset wins.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input logic [3:0] ptr, input int n);
        pick_t      p;
        logic [3:0] t;
        p = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            t = 4'((int'(ptr) + k) % n);
            if (k <= n && valid[t]) p = '{found: 1'b1, idx: t};
        end
        return p;
    endfunction
endpackage

// File: rtl/nn_mul_core.sv
// nn_mul_core: combinational unsigned multiply, product truncated to DOUT_WIDTH LSBs.
module nn_mul_core
    import nn_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
    parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH
) (
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic [DOUT_WIDTH-1:0] dout
);
    localparam int PW = (DIN0_WIDTH + DIN1_WIDTH > DOUT_WIDTH) ? DIN0_WIDTH + DIN1_WIDTH : DOUT_WIDTH;

    assign dout = DOUT_WIDTH'(PW'(din0) * PW'(din1));
endmodule

// File: rtl/nn_mul_share_arb.sv
// nn_mul_share_arb: round-robin sharing of one multiplier between NUM_REQ requesters.
// NN_MUL_PIPE_EN adds an operand stage for 2-cycle latency; default is a single result register.
module nn_mul_share_arb
    import nn_mul_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
    parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ID_WIDTH-1:0]           res_id,
    output logic [DOUT_WIDTH-1:0]         res_dout
);
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   gidx;
    logic [DIN0_WIDTH-1:0] sel_din0, mul_din0;
    logic [DIN1_WIDTH-1:0] sel_din1, mul_din1;
    logic [DOUT_WIDTH-1:0] mul_dout;
    logic                  accept, xfer;
    pick_t                 pk;

    assign pk       = rr_pick(MAX_REQ'(req_valid), 4'(rr_ptr), NUM_REQ);
    assign gidx     = ID_WIDTH'(pk.idx);
    assign sel_din0 = req_din0[gidx*DIN0_WIDTH +: DIN0_WIDTH];
    assign sel_din1 = req_din1[gidx*DIN1_WIDTH +: DIN1_WIDTH];
    assign req_ready = (ap_rst_n && accept && pk.found) ? NUM_REQ'(1) << gidx : '0;
    assign xfer     = |req_ready;

    nn_mul_core #(
        .DIN0_WIDTH(DIN0_WIDTH),
        .DIN1_WIDTH(DIN1_WIDTH),
        .DOUT_WIDTH(DOUT_WIDTH)
    ) u_core (
        .din0(mul_din0),
        .din1(mul_din1),
        .dout(mul_dout)
    );

`ifdef NN_MUL_PIPE_EN
    logic                  s1_valid, adv;
    logic [ID_WIDTH-1:0]   s1_id;
    logic [DIN0_WIDTH-1:0] s1_din0;
    logic [DIN1_WIDTH-1:0] s1_din1;

    assign adv      = !res_valid || res_ready;
    assign accept   = !s1_valid || adv;
    assign mul_din0 = s1_din0;
    assign mul_din1 = s1_din1;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s1_din0   <= '0;
            s1_din1   <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_dout  <= '0;
            rr_ptr    <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            if (xfer) begin
                rr_ptr  <= gidx;
                s1_id   <= gidx;
                s1_din0 <= sel_din0;
                s1_din1 <= sel_din1;
            end
            if (accept) s1_valid <= xfer;
            // An empty stage 1 leaves the last id/product visible on the result port.
            if (adv) begin
                res_valid <= s1_valid;
                if (s1_valid) begin
                    res_id   <= s1_id;
                    res_dout <= mul_dout;
                end
            end
        end
    end
`else
    assign accept   = !res_valid || res_ready;
    assign mul_din0 = sel_din0;
    assign mul_din1 = sel_din1;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_dout  <= '0;
            rr_ptr    <= ID_WIDTH'(NUM_REQ - 1);
        end else if (xfer) begin
            res_valid <= 1'b1;
            res_id    <= gidx;
            res_dout  <= mul_dout;
            rr_ptr    <= gidx;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end
`endif
endmodule
